mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Moore-style control FSM that sequences the shared multicycle MIPS datapath: PC, IR, unified instruction/data memory port, register file and ALU.
- Walks each instruction through fetch, decode, execute, memory and writeback.
- Waits on a memory-ready handshake.
- Halts on an all-zero instruction word, matching the zero-filled instruction image, or on an unsupported opcode.
- Sits beside the datapath inside cpu; the datapath supplies IR fields and the ALU zero flag.

Parameters:
CNT_W, 16, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
run  input  1  start enable; sampled only in IDLE
opcode  input  6  IR[31:26]
funct  input  6  IR[5:0]
instr_zero  input  1  IR == 32'h0
alu_zero  input  1  ALU result == 0
mem_ready  input  1  memory completes current access this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if alu_zero
ir_write  output  1  IR load
iord  output  1  memory address: 0=PC, 1=ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
mem_to_reg  output  1  RF write data: 0=ALUOut, 1=MDR
reg_dst  output  1  RF dest: 0=rt, 1=rd
reg_write  output  1  RF write enable
alu_src_a  output  1  0=PC, 1=A
alu_src_b  output  2  00=B, 01=4, 10=sext(imm), 11=sext(imm)<<2
alu_op  output  4  0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt
pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target
state  output  4  current state encoding, debug
halted  output  1  in HALT
illegal  output  1  sticky: halted on unsupported opcode/funct
retired  output  CNT_W  completed-instruction count

Behaviour:
- States and encodings:
  - IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6
  - EXEC=7, ALUWB=8, ADDIEX=9, ADDIWB=10, BRANCH=11, JUMP=12, HALT=13
- Reset (rst=0, async): state=IDLE, illegal=0, retired=0. All control outputs are 0 in IDLE and HALT, alu_op=0010. halted=1 only in HALT.
- Reset mid-instruction aborts immediately; no partial writes are asserted after rst falls.
- IDLE: go to FETCH when run=1.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, add, pc_source=00.
  - While mem_ready=0: hold in FETCH, ir_write=pc_write=0.
  - When mem_ready=1: ir_write=pc_write=1 that cycle, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, add (branch target into ALUOut). Next state by priority:
  - instr_zero → HALT
  - opcode 0x23/0x2B → MEMADR
  - 0x00 with funct in {0x20,0x22,0x24,0x25,0x2A} → EXEC
  - 0x08 → ADDIEX
  - 0x04 → BRANCH
  - 0x02 → JUMP
  - else → HALT with illegal set.
- MEMADR: alu_src_a=1, alu_src_b=10, add. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, iord=1. Hold until mem_ready, then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Go to FETCH.
- MEMWR: mem_write=1, iord=1. Hold until mem_ready, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op from funct (0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt). Go to ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Go to FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, add. Go to ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_write_cond=1, pc_source=01. Go to FETCH.
- JUMP: pc_write=1, pc_source=10. Go to FETCH.
- HALT: sticky until reset; run ignored.
- Instruction latency with mem_ready always 1:
  - lw 5 cycles; sw, R-type, addi 4; beq, j 3.
- retired increments by 1, wrapping at 2^CNT_W, on the final cycle of each instruction:
  - MEMWB, MEMWR with mem_ready, ALUWB, ADDIWB, BRANCH, JUMP.
- Halt and illegal instructions are not counted.
- mem_read and mem_write are never both 1. Only one of pc_write and pc_write_cond is asserted in any state.

Test Plan:
- Reset held, then released with run=1. IR stream: 0x20010001 (addi), 0x00210820 (add), 0x20010007, 0x00210820, then 0x0, mem_ready=1 → state trace 1,2,9,10,1,2,7,8 ×2, then 1,2,13; retired=4, halted=1, illegal=0.
- lw (0x8C220004) with mem_ready low 3 cycles in MEMRD → FETCH exit at cycle 1, MEMRD held 4 cycles with mem_read=iord=1, reg_write pulse 1 cycle in MEMWB; retired +1.
- beq (0x10000002): alu_zero=1 → pc_write_cond=1, pc_source=01 in BRANCH. Second run with alu_zero=0 gives identical control outputs; 3 cycles each.
- Opcode 0x3F → DECODE→HALT; illegal=1, retired unchanged; run toggling has no effect.
- rst pulled low in the middle of MEMWR with mem_ready=0 → mem_write drops asynchronously, state=0, retired=0, illegal=0.
- CNT_W=2, five addi instructions → retired wraps to 1.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Moore-style control FSM for the shared multicycle MIPS datapath.
// Walks instructions through fetch/decode/execute/memory/writeback and counts retirements.
module mips_multicycle_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             instr_zero,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,  S_MEMWB  = 4'd5,  S_MEMWR  = 4'd6,  S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_BRANCH = 4'd11,
        S_JUMP   = 4'd12, S_HALT   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J  = 6'h02, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08, OP_LW = 6'h23, OP_SW  = 6'h2B;

    localparam logic [3:0] ALU_ADD = 4'b0010, ALU_SUB = 4'b0110, ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001, ALU_SLT = 4'b0111;

    state_t           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q;
    logic             retire;
    logic             funct_ok;
    logic [3:0]       funct_op;

    // Branch resolution happens in the datapath (pc_write_cond & alu_zero), so this FSM never reads the flag.
    logic unused_alu_zero;
    assign unused_alu_zero = alu_zero;

    always_comb begin
        funct_ok = 1'b1;
        funct_op = ALU_ADD;
        case (funct)
            6'h20:   funct_op = ALU_ADD;
            6'h22:   funct_op = ALU_SUB;
            6'h24:   funct_op = ALU_AND;
            6'h25:   funct_op = ALU_OR;
            6'h2A:   funct_op = ALU_SLT;
            default: funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no path through the case infers a latch.
        state_d       = state_q;
        illegal_d     = illegal_q;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = ALU_ADD;
        pc_source     = 2'b00;

        case (state_q)
            S_IDLE: if (run) state_d = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                if (instr_zero)                               state_d = S_HALT;
                else if (opcode == OP_LW || opcode == OP_SW)  state_d = S_MEMADR;
                else if (opcode == OP_RTYPE && funct_ok)      state_d = S_EXEC;
                else if (opcode == OP_ADDI)                   state_d = S_ADDIEX;
                else if (opcode == OP_BEQ)                    state_d = S_BRANCH;
                else if (opcode == OP_J)                      state_d = S_JUMP;
                else begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = funct_op;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            if (retire) retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign state   = state_q;
    assign halted  = (state_q == S_HALT);
    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: a vector table for a short program,
// then directed sequences for memory stalls, branches, illegal opcodes, async abort and counter wrap.
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst, run, instr_zero, alu_zero, mem_ready;
    logic [5:0]  opcode, funct;

    logic        pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a, halted, illegal;
    logic [1:0]  alu_src_b, pc_source;
    logic [3:0]  alu_op, state;
    logic [15:0] retired;

    logic        n_pc_write, n_pc_write_cond, n_ir_write, n_iord, n_mem_read, n_mem_write;
    logic        n_mem_to_reg, n_reg_dst, n_reg_write, n_alu_src_a, n_halted, n_illegal;
    logic [1:0]  n_alu_src_b, n_pc_source;
    logic [3:0]  n_alu_op, n_state;
    logic [1:0]  n_retired;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct(funct),
        .instr_zero(instr_zero), .alu_zero(alu_zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source), .state(state),
        .halted(halted), .illegal(illegal), .retired(retired)
    );

    mips_multicycle_ctrl #(.CNT_W(2)) u_dut_n (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct(funct),
        .instr_zero(instr_zero), .alu_zero(alu_zero), .mem_ready(mem_ready),
        .pc_write(n_pc_write), .pc_write_cond(n_pc_write_cond), .ir_write(n_ir_write),
        .iord(n_iord), .mem_read(n_mem_read), .mem_write(n_mem_write), .mem_to_reg(n_mem_to_reg),
        .reg_dst(n_reg_dst), .reg_write(n_reg_write), .alu_src_a(n_alu_src_a),
        .alu_src_b(n_alu_src_b), .alu_op(n_alu_op), .pc_source(n_pc_source), .state(n_state),
        .halted(n_halted), .illegal(n_illegal), .retired(n_retired)
    );

    logic [17:0] act_ctrl;
    assign act_ctrl = {pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write,
                       mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

    typedef struct {
        logic [31:0] ir;
        logic        run;
        logic        mem_ready;
        logic [3:0]  st;
        logic [17:0] ctrl;
        logic [15:0] ret;
        logic        halt;
    } vec_t;

    vec_t vecs[32];
    int   nv;
    int   checks = 0;
    int   errors = 0;

    localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0110;

    logic [17:0] C_IDLE, C_FETCH, C_FWAIT, C_DEC, C_MADR, C_MRD, C_MWB, C_MWR;
    logic [17:0] C_EXADD, C_AWB, C_AIWB, C_BR, C_J;

    function automatic logic [17:0] cv(input logic pcw, input logic pcc, input logic irw,
                                       input logic io, input logic mr, input logic mw,
                                       input logic m2r, input logic rd, input logic rw,
                                       input logic sa, input logic [1:0] sb,
                                       input logic [3:0] op, input logic [1:0] ps);
        return {pcw, pcc, irw, io, mr, mw, m2r, rd, rw, sa, sb, op, ps};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_ir(input logic [31:0] w);
        opcode     = w[31:26];
        funct      = w[5:0];
        instr_zero = (w == 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle_check(input string name, input logic [3:0] st, input logic [17:0] c);
        #1;
        check({name, " state"}, {28'h0, state}, {28'h0, st});
        check({name, " ctrl"}, {14'h0, act_ctrl}, {14'h0, c});
    endtask

    task automatic cyc(input string name, input logic [3:0] st, input logic [17:0] c);
        settle_check(name, st, c);
        step();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        run = 1'b0;
        mem_ready = 1'b1;
        alu_zero = 1'b0;
        set_ir(32'h0);
        step();
        step();
        settle_check("reset", 4'd0, C_IDLE);
        check("reset retired", {16'h0, retired}, 32'h0);
        check("reset illegal", {31'h0, illegal}, 32'h0);
        check("reset halted", {31'h0, halted}, 32'h0);
        rst = 1'b1;
    endtask

    task automatic add_vec(input logic [31:0] ir, input logic r, input logic [3:0] st,
                           input logic [17:0] c, input logic [15:0] ret, input logic h);
        vecs[nv] = '{ir: ir, run: r, mem_ready: 1'b1, st: st, ctrl: c, ret: ret, halt: h};
        nv++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        C_IDLE  = cv(0,0,0,0,0,0,0,0,0,0, 2'b00, ADD, 2'b00);
        C_FETCH = cv(1,0,1,0,1,0,0,0,0,0, 2'b01, ADD, 2'b00);
        C_FWAIT = cv(0,0,0,0,1,0,0,0,0,0, 2'b01, ADD, 2'b00);
        C_DEC   = cv(0,0,0,0,0,0,0,0,0,0, 2'b11, ADD, 2'b00);
        C_MADR  = cv(0,0,0,0,0,0,0,0,0,1, 2'b10, ADD, 2'b00);
        C_MRD   = cv(0,0,0,1,1,0,0,0,0,0, 2'b00, ADD, 2'b00);
        C_MWB   = cv(0,0,0,0,0,0,1,0,1,0, 2'b00, ADD, 2'b00);
        C_MWR   = cv(0,0,0,1,0,1,0,0,0,0, 2'b00, ADD, 2'b00);
        C_EXADD = cv(0,0,0,0,0,0,0,0,0,1, 2'b00, ADD, 2'b00);
        C_AWB   = cv(0,0,0,0,0,0,0,1,1,0, 2'b00, ADD, 2'b00);
        C_AIWB  = cv(0,0,0,0,0,0,0,0,1,0, 2'b00, ADD, 2'b00);
        C_BR    = cv(0,1,0,0,0,0,0,0,0,1, 2'b00, SUB, 2'b01);
        C_J     = cv(1,0,0,0,0,0,0,0,0,0, 2'b00, ADD, 2'b10);

        // Program: addi, add, addi, add, then the zero word.
        nv = 0;
        add_vec(32'h20010001, 1, 4'd0,  C_IDLE,  0, 0);
        add_vec(32'h20010001, 1, 4'd1,  C_FETCH, 0, 0);
        add_vec(32'h20010001, 1, 4'd2,  C_DEC,   0, 0);
        add_vec(32'h20010001, 1, 4'd9,  C_MADR,  0, 0);
        add_vec(32'h20010001, 1, 4'd10, C_AIWB,  0, 0);
        add_vec(32'h00210820, 1, 4'd1,  C_FETCH, 1, 0);
        add_vec(32'h00210820, 1, 4'd2,  C_DEC,   1, 0);
        add_vec(32'h00210820, 1, 4'd7,  C_EXADD, 1, 0);
        add_vec(32'h00210820, 1, 4'd8,  C_AWB,   1, 0);
        add_vec(32'h20010007, 1, 4'd1,  C_FETCH, 2, 0);
        add_vec(32'h20010007, 1, 4'd2,  C_DEC,   2, 0);
        add_vec(32'h20010007, 1, 4'd9,  C_MADR,  2, 0);
        add_vec(32'h20010007, 1, 4'd10, C_AIWB,  2, 0);
        add_vec(32'h00210820, 1, 4'd1,  C_FETCH, 3, 0);
        add_vec(32'h00210820, 1, 4'd2,  C_DEC,   3, 0);
        add_vec(32'h00210820, 1, 4'd7,  C_EXADD, 3, 0);
        add_vec(32'h00210820, 1, 4'd8,  C_AWB,   3, 0);
        add_vec(32'h00000000, 1, 4'd1,  C_FETCH, 4, 0);
        add_vec(32'h00000000, 1, 4'd2,  C_DEC,   4, 0);
        add_vec(32'h00000000, 1, 4'd13, C_IDLE,  4, 1);
        add_vec(32'h00000000, 0, 4'd13, C_IDLE,  4, 1);

        do_reset();
        for (int i = 0; i < nv; i++) begin
            set_ir(vecs[i].ir);
            run       = vecs[i].run;
            mem_ready = vecs[i].mem_ready;
            settle_check($sformatf("prog[%0d]", i), vecs[i].st, vecs[i].ctrl);
            check($sformatf("prog[%0d] retired", i), {16'h0, retired}, {16'h0, vecs[i].ret});
            check($sformatf("prog[%0d] halted", i), {31'h0, halted}, {31'h0, vecs[i].halt});
            step();
        end
        check("prog illegal", {31'h0, illegal}, 32'h0);

        // lw with a fetch stall and a 3-cycle read stall.
        do_reset();
        run = 1'b1;
        set_ir(32'h8C220004);
        cyc("lw idle", 4'd0, C_IDLE);
        mem_ready = 1'b0;
        cyc("lw fetch wait", 4'd1, C_FWAIT);
        mem_ready = 1'b1;
        cyc("lw fetch", 4'd1, C_FETCH);
        cyc("lw decode", 4'd2, C_DEC);
        cyc("lw memadr", 4'd3, C_MADR);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc($sformatf("lw memrd stall%0d", i), 4'd4, C_MRD);
        mem_ready = 1'b1;
        cyc("lw memrd done", 4'd4, C_MRD);
        check("lw retired pre-wb", {16'h0, retired}, 32'd0);
        cyc("lw memwb", 4'd5, C_MWB);

        // beq taken, then not taken: identical control and timing.
        set_ir(32'h10000002);
        for (int k = 0; k < 2; k++) begin
            alu_zero = (k == 0);
            check($sformatf("beq%0d retired start", k), {16'h0, retired}, 32'd1 + k);
            cyc($sformatf("beq%0d fetch", k), 4'd1, C_FETCH);
            cyc($sformatf("beq%0d decode", k), 4'd2, C_DEC);
            cyc($sformatf("beq%0d branch", k), 4'd11, C_BR);
        end
        alu_zero = 1'b0;

        // Remaining R-type ALU operations, then a jump.
        begin
            logic [5:0] fns[4];
            logic [3:0] ops[4];
            fns = '{6'h22, 6'h24, 6'h25, 6'h2A};
            ops = '{4'b0110, 4'b0000, 4'b0001, 4'b0111};
            for (int k = 0; k < 4; k++) begin
                set_ir({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, fns[k]});
                cyc($sformatf("rtype%0d fetch", k), 4'd1, C_FETCH);
                cyc($sformatf("rtype%0d decode", k), 4'd2, C_DEC);
                cyc($sformatf("rtype%0d exec", k), 4'd7, cv(0,0,0,0,0,0,0,0,0,1, 2'b00, ops[k], 2'b00));
                cyc($sformatf("rtype%0d aluwb", k), 4'd8, C_AWB);
            end
        end
        set_ir(32'h08000010);
        cyc("j fetch", 4'd1, C_FETCH);
        cyc("j decode", 4'd2, C_DEC);
        cyc("j jump", 4'd12, C_J);
        check("retired after j", {16'h0, retired}, 32'd8);

        // sw stalled in MEMWR, aborted by asynchronous reset mid-cycle.
        set_ir(32'hAC220004);
        cyc("sw fetch", 4'd1, C_FETCH);
        cyc("sw decode", 4'd2, C_DEC);
        cyc("sw memadr", 4'd3, C_MADR);
        mem_ready = 1'b0;
        cyc("sw memwr stall", 4'd6, C_MWR);
        settle_check("sw memwr stall2", 4'd6, C_MWR);
        #2;
        rst = 1'b0;
        #1;
        check("abort mem_write", {31'h0, mem_write}, 32'h0);
        check("abort state", {28'h0, state}, 32'h0);
        check("abort retired", {16'h0, retired}, 32'h0);
        check("abort illegal", {31'h0, illegal}, 32'h0);
        step();
        rst = 1'b1;
        mem_ready = 1'b1;

        // Unsupported opcode halts with illegal set; run is then ignored.
        run = 1'b1;
        set_ir(32'hFC000000);
        cyc("ill idle", 4'd0, C_IDLE);
        cyc("ill fetch", 4'd1, C_FETCH);
        cyc("ill decode", 4'd2, C_DEC);
        for (int i = 0; i < 4; i++) begin
            run = i[0];
            settle_check($sformatf("ill halt%0d", i), 4'd13, C_IDLE);
            check($sformatf("ill illegal%0d", i), {31'h0, illegal}, 32'h1);
            check($sformatf("ill halted%0d", i), {31'h0, halted}, 32'h1);
            check($sformatf("ill retired%0d", i), {16'h0, retired}, 32'h0);
            step();
        end

        // Unsupported R-type funct is also illegal.
        do_reset();
        run = 1'b1;
        set_ir(32'h00000001);
        repeat (3) step();
        settle_check("badfunct halt", 4'd13, C_IDLE);
        check("badfunct illegal", {31'h0, illegal}, 32'h1);

        // Counter wrap on the 2-bit instance after five addi.
        do_reset();
        run = 1'b1;
        set_ir(32'h20010001);
        step();
        for (int k = 0; k < 5; k++) begin
            repeat (4) step();
            if (k == 3) check("wrap narrow after 4", {30'h0, n_retired}, 32'd0);
        end
        set_ir(32'h0);
        check("wrap narrow after 5", {30'h0, n_retired}, 32'd1);
        check("wrap wide after 5", {16'h0, retired}, 32'd5);
        check("wrap state fetch", {28'h0, state}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
